// File: rtl/rst_sequencer.sv
// Reset sequencer: merges POR, debounced push-button and debug reset requests,
// qualifies PLL lock and releases system then peripheral reset in order.
module rst_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES     = 64,
  parameter int unsigned HOLD_CYCLES     = 32,
  parameter int unsigned PERIPH_DELAY    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ext_rst_ni,
  input  logic       ndm_req_i,
  input  logic       pll_lock_i,
  input  logic       rst_cause_clr_i,
  output logic       sys_rst_no,
  output logic       periph_rst_no,
  output logic       ndm_ack_o,
  output logic [3:0] rst_cause_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CntMax = (LOCK_CYCLES > HOLD_CYCLES) ?
                                   ((LOCK_CYCLES > PERIPH_DELAY) ? LOCK_CYCLES : PERIPH_DELAY) :
                                   ((HOLD_CYCLES > PERIPH_DELAY) ? HOLD_CYCLES : PERIPH_DELAY);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StPor,
    StWaitLock,
    StHold,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DbW-1:0]         db_cnt_q;
  logic [CntW-1:0]        cnt_q;
  logic                   ext_act_q;
  logic                   ndm_pend_q;

  logic       ext_act;
  logic       ext_rise;
  logic       ev_lock;
  logic       in_active;
  logic       ev_any;
  logic [3:0] new_cause;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '1;
      db_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_ni};
      if (sync_q[SYNC_STAGES-1]) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q != DbW'(DEBOUNCE_CYCLES)) begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ext_act   = (db_cnt_q == DbW'(DEBOUNCE_CYCLES));
    ext_rise  = ext_act & ~ext_act_q;
    ev_lock   = ~pll_lock_i;
    in_active = (state_q == StRelease) || (state_q == StRun);
    ev_any    = in_active & (ev_lock | ext_rise | ndm_req_i);
    new_cause = in_active ? {ev_lock, ndm_req_i, ext_rise, 1'b0} : 4'b0000;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StPor;
      sys_rst_no    <= 1'b0;
      periph_rst_no <= 1'b0;
      ndm_ack_o     <= 1'b0;
      rst_cause_o   <= 4'b0001;
      cnt_q         <= '0;
      ndm_pend_q    <= 1'b0;
      ext_act_q     <= 1'b0;
    end else begin
      ext_act_q   <= ext_act;
      ndm_ack_o   <= 1'b0;
      // A clear coinciding with a new event still leaves the event's bit set.
      rst_cause_o <= (((state_q == StRun) && rst_cause_clr_i) ? 4'b0000 : rst_cause_o)
                     | new_cause;
      if (ev_any) begin
        sys_rst_no    <= 1'b0;
        periph_rst_no <= 1'b0;
        cnt_q         <= '0;
        if (ndm_req_i) ndm_pend_q <= 1'b1;
        state_q <= ev_lock ? StWaitLock : StHold;
      end else begin
        unique case (state_q)
          StPor: begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end
          StWaitLock: begin
            if (!pll_lock_i) begin
              cnt_q <= '0;
            end else if (cnt_q == CntW'(LOCK_CYCLES - 1)) begin
              state_q <= StHold;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StHold: begin
            if (!pll_lock_i) begin
              state_q <= StWaitLock;
              cnt_q   <= '0;
            end else if (ext_act) begin
              cnt_q <= '0;
            end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
              state_q    <= StRelease;
              cnt_q      <= '0;
              sys_rst_no <= 1'b1;
              ndm_ack_o  <= ndm_pend_q;
              ndm_pend_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRelease: begin
            if (cnt_q == CntW'(PERIPH_DELAY - 1)) begin
              state_q       <= StRun;
              cnt_q         <= '0;
              periph_rst_no <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRun: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= StPor;
          end
        endcase
      end
    end
  end

endmodule
